pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter sequencer directly downstream of the jump-condition stage.
//  Consumes its 'taken' decision with the decoded jump target, and produces the fetch PC.
//  Also produces a one-cycle flush pulse that kills the wrong-path instruction already in fetch.
//  Optionally holds a small circular return-address stack for call/return.
// PARAMETERS
//  PC_W        16  program-counter width in bits
//  RESET_PC    0   PC value loaded by reset; also the fallback target on stack underflow
//  STACK_DEPTH 4   return-stack entries (power of 2, >=2); used only with RAS_EN
// PORTS
//  clk          in   1     system clock, all state on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  stall        in   1     hold PC; all control inputs ignored this cycle
//  jump_valid   in   1     decode stage presents a jump/call instruction this cycle
//  taken        in   1     condition result from the jump-condition stage
//  call         in   1     qualifies jump_valid as a call (push return address)
//  ret          in   1     return strobe (pop); independent of jump_valid/taken
//  jump_target  in   PC_W  absolute target for jump/call
//  pc           out  PC_W  current fetch address (registered)
//  fetch_valid  out  1     pc is a valid fetch address
//  flush        out  1     discard instruction fetched in previous cycle (registered)
//  stack_err    out  1     sticky: return-stack overflow or underflow (0 without RAS_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, fetch_valid=0, flush=0, stack_err=0.
//   Stack pointer=0, depth count=0, state=BOOT.
//  FSM: BOOT -> RUN after the first clock edge with rst_n=1.
//   No other transitions; stall does not affect BOOT.
//  BOOT: pc holds RESET_PC, fetch_valid=0. RUN: fetch_valid=1 every cycle.
//  RUN priority per edge (highest first):
//   1. stall=1: pc, stack, and stack_err hold; flush<=0.
//   2. ret=1: redirect to the popped address; flush<=1; call/jump_valid ignored this cycle.
//   3. jump_valid&taken: pc<=jump_target; flush<=1.
//      If call=1, also push pc+1 (mod 2^PC_W).
//   4. otherwise: pc<=pc+1 modulo 2^PC_W (0xFFFF wraps to 0x0000 at PC_W=16); flush<=0.
//  jump_valid&!taken behaves as case 4; call without a taken jump pushes nothing.
//  Latency: a redirect sampled at edge N shows pc=target and flush=1 in cycle N+1.
//   flush is never high for two consecutive cycles unless redirects are back-to-back.
//  flush is never asserted in BOOT.
//  Arithmetic: the PC incrementer is PC_W bits wide; the carry out is discarded.
//  Reset mid-operation: all state returns to reset values immediately (async).
//   Stack contents are don't-care after reset; depth count=0.
// CONFIGURATION
//  RAS_EN defined:
//   - circular stack of STACK_DEPTH x PC_W entries.
//   - push when full overwrites the oldest entry; depth stays STACK_DEPTH; stack_err<=1.
//   - pop when empty redirects to RESET_PC; flush<=1; stack_err<=1.
//   - stack_err clears only on reset.
//  RAS_EN undefined:
//   - no stack storage.
//   - call is a plain taken jump.
//   - ret is ignored (case 4 applies unless a jump is taken).
//   - stack_err tied 0.
// TESTING
//  1. Reset release, no jumps -> cycle 1 BOOT pc=0 fetch_valid=0.
//     Then pc=0,1,2,3 with fetch_valid=1, flush=0.
//  2. At pc=5: jump_valid=1, taken=1, target=0x0040 -> next cycle pc=0x0040, flush=1.
//     Then pc=0x0041, flush=0.
//     Same with taken=0 -> pc=6, no flush.
//  3. stall=1 for 3 cycles with jump_valid&taken asserted -> pc frozen, flush=0.
//     On the first cycle with stall=0 the jump is taken.
//  4. pc=0xFFFE with no jumps -> 0xFFFF, then 0x0000 (wrap, no flush).
//  5. RAS_EN: call at pc=0x10 to 0x80, ret at 0x82 -> pc=0x11, flush=1, stack_err=0.
//     Ret with an empty stack -> pc=RESET_PC, stack_err=1 (sticky).
//     Five nested calls with DEPTH=4 -> stack_err=1; four rets return the newest four addresses.
//  6. ret and taken call in the same cycle -> ret wins, no push.
//     Without RAS_EN: same stimulus -> jump to target, ret ignored, stack_err=0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the decode/jump-condition stages and the PC sequencer.
interface pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            jump_valid;
    logic            taken;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic            flush;
    logic            stack_err;

    modport master (
        output stall, jump_valid, taken, call, ret, jump_target,
        input  pc, fetch_valid, flush, stack_err
    );

    modport slave (
        input  stall, jump_valid, taken, call, ret, jump_target,
        output pc, fetch_valid, flush, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer with redirect flush and optional return-address stack (RAS_EN).
// Latency: a redirect sampled at edge N shows pc=target and flush=1 in cycle N+1.
// Backpressure: stall freezes pc, stack and stack_err; controls are ignored that cycle.
module pc_sequencer #(
    parameter int          PC_W        = 16,
    parameter int unsigned RESET_PC    = 0,
    parameter int          STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic            r_flush;
    logic            w_flush_nxt;
    logic            w_ret_act;
    logic [PC_W-1:0] w_ret_pc;

    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                if (bus.stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_ret_act) begin
                    w_pc_nxt    = w_ret_pc;
                    w_flush_nxt = 1'b1;
                end else if (bus.jump_valid && bus.taken) begin
                    w_pc_nxt    = bus.jump_target;
                    w_flush_nxt = 1'b1;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RST_PC;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= w_flush_nxt;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.fetch_valid = (r_state == RUN);
    assign bus.flush       = r_flush;

`ifdef RAS_EN
    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;
    logic [SP_W:0]   r_cnt;
    logic            r_err;
    logic            w_live;
    logic            w_push;
    logic            w_empty;
    logic            w_full;

    assign w_live    = (r_state == RUN) && !bus.stall;
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == (SP_W+1)'(STACK_DEPTH));
    assign w_ret_act = w_live && bus.ret;
    // Underflow falls back to the reset vector rather than stale stack data.
    assign w_ret_pc  = w_empty ? RST_PC : r_stack[r_sp - SP_W'(1)];
    assign w_push    = w_live && !bus.ret && bus.jump_valid && bus.taken && bus.call;

    // r_sp is the next write slot; it wraps, so a full push overwrites the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_push) begin
            r_sp <= r_sp + SP_W'(1);
            if (w_full) r_err <= 1'b1;
            else        r_cnt <= r_cnt + (SP_W+1)'(1);
        end else if (w_ret_act) begin
            if (w_empty) begin
                r_err <= 1'b1;
            end else begin
                r_sp  <= r_sp - SP_W'(1);
                r_cnt <= r_cnt - (SP_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_stack[r_sp] <= w_pc_inc;
    end

    assign bus.stack_err = r_err;
`else
    assign w_ret_act     = 1'b0;
    assign w_ret_pc      = RST_PC;
    assign bus.stack_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized + directed bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    localparam int          PC_W     = 16;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

`ifdef RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(0), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a running flag, the pc, and the return stack as a plain queue.
    bit          m_run;
    logic [15:0] m_pc;
    bit          m_flush;
    bit          m_err;
    logic [15:0] m_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   = 1'b0;
            m_pc    = RESET_PC;
            m_flush = 1'b0;
            m_err   = 1'b0;
            m_q.delete();
        end else if (!m_run) begin
            m_run   = 1'b1;
            m_flush = 1'b0;
        end else if (bus.stall) begin
            m_flush = 1'b0;
        end else if (RAS && bus.ret) begin
            if (m_q.size() == 0) begin
                m_pc  = RESET_PC;
                m_err = 1'b1;
            end else begin
                m_pc = m_q.pop_back();
            end
            m_flush = 1'b1;
        end else if (bus.jump_valid && bus.taken) begin
            if (RAS && bus.call) begin
                m_q.push_back(m_pc + 16'd1);
                if (m_q.size() > DEPTH) begin
                    void'(m_q.pop_front());
                    m_err = 1'b1;
                end
            end
            m_pc    = bus.jump_target;
            m_flush = 1'b1;
        end else begin
            m_pc    = m_pc + 16'd1;
            m_flush = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("pc", 32'(bus.pc), 32'(m_pc));
        chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_run));
        chk("flush", 32'(bus.flush), 32'(m_flush));
        chk("stack_err", 32'(bus.stack_err), 32'(m_err));
    end

    task automatic drive(input bit st, input bit jv, input bit tk, input bit cl,
                         input bit rt, input logic [15:0] tgt);
        bus.stall       = st;
        bus.jump_valid  = jv;
        bus.taken       = tk;
        bus.call        = cl;
        bus.ret         = rt;
        bus.jump_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 16'h0);
        repeat (n) step();
    endtask

    task automatic lit(input string name, input logic [15:0] pc, input bit fl, input bit er);
        chk({name, ".pc"}, 32'(bus.pc), 32'(pc));
        chk({name, ".flush"}, 32'(bus.flush), 32'(fl));
        chk({name, ".err"}, 32'(bus.stack_err), 32'(er));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst.pc", 32'(bus.pc), 32'(RESET_PC));
        chk("rst.fv", 32'(bus.fetch_valid), 32'd0);
        chk("rst.err", 32'(bus.stack_err), 32'd0);
        step();
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 16'h0);
        repeat (2) step();
        chk("boot.fv", 32'(bus.fetch_valid), 32'd0);
        rst_n = 1'b1;
        #2;
        chk("boot1.fv", 32'(bus.fetch_valid), 32'd0);
        chk("boot1.pc", 32'(bus.pc), 32'd0);
        idle(1);
        lit("run0", 16'h0000, 0, 0);
        chk("run0.fv", 32'(bus.fetch_valid), 32'd1);
        idle(3);
        lit("run3", 16'h0003, 0, 0);

        idle(2);
        lit("at5", 16'h0005, 0, 0);
        drive(0, 1, 1, 0, 0, 16'h0040); step();
        lit("jmp", 16'h0040, 1, 0);
        idle(1);
        lit("jmp+1", 16'h0041, 0, 0);
        drive(0, 1, 0, 0, 0, 16'h0040); step();
        lit("nottaken", 16'h0042, 0, 0);

        drive(1, 1, 1, 0, 0, 16'h0100);
        repeat (3) step();
        lit("stall", 16'h0042, 0, 0);
        drive(0, 1, 1, 0, 0, 16'h0100); step();
        lit("unstall", 16'h0100, 1, 0);

        drive(0, 1, 1, 0, 0, 16'hFFFE); step();
        idle(1);
        lit("ffff", 16'hFFFF, 0, 0);
        idle(1);
        lit("wrap", 16'h0000, 0, 0);

`ifdef RAS_EN
        drive(0, 1, 1, 0, 0, 16'h0010); step();
        drive(0, 1, 1, 1, 0, 16'h0080); step();
        idle(2);
        lit("at82", 16'h0082, 0, 0);
        drive(0, 0, 0, 0, 1, 16'h0); step();
        lit("ret", 16'h0011, 1, 0);
        drive(0, 0, 0, 0, 1, 16'h0); step();
        lit("underflow", RESET_PC, 1, 1);
        idle(3);
        lit("sticky", 16'h0003, 0, 1);

        do_reset();
        drive(0, 1, 1, 1, 0, 16'h0100); step();
        drive(0, 1, 1, 1, 0, 16'h0200); step();
        drive(0, 1, 1, 1, 0, 16'h0300); step();
        drive(0, 1, 1, 1, 0, 16'h0400); step();
        lit("call4", 16'h0400, 1, 0);
        drive(0, 1, 1, 1, 0, 16'h0500); step();
        lit("overflow", 16'h0500, 1, 1);
        drive(0, 0, 0, 0, 1, 16'h0); step();
        lit("r1", 16'h0401, 1, 1);
        step(); lit("r2", 16'h0301, 1, 1);
        step(); lit("r3", 16'h0201, 1, 1);
        step(); lit("r4", 16'h0101, 1, 1);

        do_reset();
        drive(0, 1, 1, 1, 0, 16'h0700); step();
        drive(0, 1, 1, 1, 1, 16'h0900); step();
        lit("retwins", 16'h0001, 1, 0);
        drive(0, 0, 0, 0, 1, 16'h0); step();
        lit("nopush", RESET_PC, 1, 1);
`else
        drive(0, 1, 1, 1, 1, 16'h0200); step();
        lit("noras", 16'h0200, 1, 0);
        drive(0, 0, 0, 0, 1, 16'h0); step();
        lit("retign", 16'h0201, 0, 0);
`endif

        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 9) == 0, 16'($urandom));
                step();
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
